mcu_spi_slave: RTL and testbench

MCU_SPI_SLAVE -- requirements
Module: mcu_spi_slave

---
 rtl/mcu_spi_slave.sv | 155 +++++++++++++++
 tb/tb_mcu_spi_slave.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave for the MCU link: synchronizes the SPI pins into clk,
// assembles received bytes and streams tx_data out MSB first on spi_miso.
//
// state  | meaning
// IDLE   | csn_s high: counter cleared, tx shifter follows tx_data
// ACTIVE | csn_s low: bytes shifted in on spi_clk rise, out on fall
module mcu_spi_slave #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       frame_end,
  input  logic [7:0] tx_data,
  output logic       tx_load
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Flush timer covers the synchronizer plus history flop, so a csn already
  // low at reset release is never seen as a fresh falling edge.
  localparam logic [2:0] FLUSH_INIT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic       sclk_d, csn_d;
  logic [2:0] flush_cnt;
  logic       sclk_s, csn_s, mosi_s, ready;
  logic       sclk_rise, sclk_fall, csn_rise, csn_fall;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       first_flag, first_flag_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       skip_fall, skip_fall_nxt;
  logic       byte_done, byte_done_nxt;
  logic       byte_first;
  logic       frame_end_nxt;
  logic       load;
  logic       miso_r, miso_nxt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ready     = (flush_cnt == 3'd0);
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ready & ~csn_s & csn_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
      flush_cnt <= FLUSH_INIT;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
      flush_cnt <= ready ? 3'd0 : flush_cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    first_flag_nxt = first_flag;
    rx_shift_nxt   = rx_shift;
    tx_shift_nxt   = tx_shift;
    skip_fall_nxt  = skip_fall;
    byte_done_nxt  = 1'b0;
    frame_end_nxt  = 1'b0;
    load           = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_nxt    = 3'd0;
        first_flag_nxt = 1'b1;
        skip_fall_nxt  = 1'b0;
        load           = ready;
        if (csn_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (csn_rise) begin
          // Frame end beats a byte completing in the same cycle.
          state_nxt     = IDLE;
          frame_end_nxt = 1'b1;
          bit_cnt_nxt   = 3'd0;
        end else if (sclk_rise) begin
          rx_shift_nxt = {rx_shift[6:0], mosi_s};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done_nxt  = 1'b1;
            first_flag_nxt = 1'b0;
            load           = 1'b1;
            skip_fall_nxt  = 1'b1;
          end
        end else if (sclk_fall) begin
          if (skip_fall) skip_fall_nxt = 1'b0;
          else           tx_shift_nxt  = {tx_shift[6:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) tx_shift_nxt = tx_data;
    miso_nxt = (state_nxt == ACTIVE) ? tx_shift_nxt[7] : IDLE_MISO;
  end

  assign tx_load  = load;
  assign spi_miso = miso_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      first_flag <= 1'b1;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      skip_fall  <= 1'b0;
      byte_done  <= 1'b0;
      byte_first <= 1'b0;
      miso_r     <= IDLE_MISO;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_start   <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      first_flag <= first_flag_nxt;
      rx_shift   <= rx_shift_nxt;
      tx_shift   <= tx_shift_nxt;
      skip_fall  <= skip_fall_nxt;
      byte_done  <= byte_done_nxt;
      byte_first <= first_flag;
      miso_r     <= miso_nxt;
      rx_valid   <= byte_done;
      rx_start   <= byte_done & byte_first;
      frame_end  <= frame_end_nxt;
      if (byte_done) rx_data <= rx_shift;
    end
  end

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Bench for mcu_spi_slave: two instances (2 and 3 sync stages) share one SPI
// master model; each byte is checked against the bytes the master sent.
module tb_mcu_spi_slave;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
  logic miso2, miso3;
  logic [7:0] rx_data2, rx_data3, tx_data2, tx_data3;
  logic rx_valid2, rx_valid3, rx_start2, rx_start3;
  logic frame_end2, frame_end3, tx_load2, tx_load3;

  int nerr = 0, nchk = 0;
  int cyc = 0;

  logic [7:0] txq[256];
  int idx2 = 0, idx3 = 0;
  bit in_frame = 1'b0, fr = 1'b0, fr_q = 1'b0, ld2 = 1'b0, ld3 = 1'b0;

  logic [7:0] rxd2[$], rxd3[$];
  bit rxs2[$], rxs3[$];
  int rxc2[$], rxc3[$];
  int fe2 = 0, fe3 = 0, fec2 = 0, fec3 = 0, bad2 = 0, bad3 = 0;

  logic [7:0] mo[64];
  logic [7:0] mi_got[2][64];
  int rise_cyc[64];
  int csn_rise_cyc, base_idx;

  mcu_spi_slave #(.SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(miso2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_start(rx_start2), .frame_end(frame_end2),
    .tx_data(tx_data2), .tx_load(tx_load2));

  mcu_spi_slave #(.SYNC_STAGES(3), .IDLE_MISO(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_mosi(spi_mosi), .spi_miso(miso3), .rx_data(rx_data3),
    .rx_valid(rx_valid3), .rx_start(rx_start3), .frame_end(frame_end3),
    .tx_data(tx_data3), .tx_load(tx_load3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // User side of the tx handshake: one byte consumed at frame start and
  // one per tx_load pulse while the frame is open.
  assign tx_data2 = txq[idx2 % 256];
  assign tx_data3 = txq[idx3 % 256];
  always @(negedge clk) begin
    ld2 <= tx_load2;
    ld3 <= tx_load3;
    fr  <= in_frame;
  end
  always @(posedge clk) begin
    fr_q <= fr;
    if (fr && (!fr_q || ld2)) idx2 <= idx2 + 1;
    if (fr && (!fr_q || ld3)) idx3 <= idx3 + 1;
  end

  always @(negedge clk) begin
    if (rx_valid2) begin rxd2.push_back(rx_data2); rxs2.push_back(rx_start2); rxc2.push_back(cyc); end
    if (rx_valid3) begin rxd3.push_back(rx_data3); rxs3.push_back(rx_start3); rxc3.push_back(cyc); end
    if (rx_start2 && !rx_valid2) bad2 <= bad2 + 1;
    if (rx_start3 && !rx_valid3) bad3 <= bad3 + 1;
    if (frame_end2) begin fe2 <= fe2 + 1; fec2 <= cyc; end
    if (frame_end3) begin fe3 <= fe3 + 1; fec3 <= cyc; end
  end

  function automatic int rxn_of(input int d);
    return (d == 0) ? rxd2.size() : rxd3.size();
  endfunction
  function automatic logic [7:0] rxd_at(input int d, input int k);
    return (d == 0) ? rxd2[k] : rxd3[k];
  endfunction
  function automatic bit rxs_at(input int d, input int k);
    return (d == 0) ? rxs2[k] : rxs3[k];
  endfunction
  function automatic int rxc_at(input int d, input int k);
    return (d == 0) ? rxc2[k] : rxc3[k];
  endfunction
  function automatic int fe_of(input int d);  return (d == 0) ? fe2 : fe3;   endfunction
  function automatic int fec_of(input int d); return (d == 0) ? fec2 : fec3; endfunction
  function automatic int bad_of(input int d); return (d == 0) ? bad2 : bad3; endfunction
  function automatic int idx_of(input int d); return (d == 0) ? idx2 : idx3; endfunction
  function automatic int s_of(input int d);   return (d == 0) ? 2 : 3;       endfunction
  function automatic logic idle_of(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction
  function automatic logic miso_of(input int d); return (d == 0) ? miso2 : miso3; endfunction
  function automatic logic [12:0] outs_of(input int d);
    return (d == 0) ? {rx_data2, rx_valid2, rx_start2, frame_end2, tx_load2, miso2}
                    : {rx_data3, rx_valid3, rx_start3, frame_end3, tx_load3, miso3};
  endfunction

  // Mode-0 master: 8-clk spi_clk period, MOSI changes on the falling edge,
  // MISO sampled at the raw rising edge.
  task automatic do_frame(input int nbytes, input int last_bits);
    int nb;
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    base_idx = idx2;
    in_frame = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      for (int i = 0; i < nb; i++) begin
        spi_mosi = mo[b][7-i];
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        mi_got[0][b][7-i] = miso2;
        mi_got[1][b][7-i] = miso3;
        if (i == 7) rise_cyc[b] = cyc;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    in_frame = 1'b0;
    csn_rise_cyc = cyc;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [12:0] exp;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp = {8'h00, 4'b0000, idle_of(d)};
      nchk++;
      if (outs_of(d) !== exp) begin
        nerr++;
        $display("FAIL reset_values dut%0d: got %h expected %h", d, outs_of(d), exp);
      end
    end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single;
    int r0[2], f0[2];
    for (int d = 0; d < 2; d++) begin r0[d] = rxn_of(d); f0[d] = fe_of(d); end
    mo[0] = 8'hA5;
    txq[idx2 % 256] = 8'h3C;
    do_frame(1, 8);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (mi_got[d][0] !== 8'h3C) begin
        nerr++; $display("FAIL single_miso dut%0d: got %h expected 3c", d, mi_got[d][0]);
      end
      nchk++;
      if (rxn_of(d) - r0[d] !== 1) begin
        nerr++; $display("FAIL single_rx_count dut%0d: got %0d expected 1", d, rxn_of(d) - r0[d]);
      end else begin
        nchk++;
        if (rxd_at(d, r0[d]) !== 8'hA5 || rxs_at(d, r0[d]) !== 1'b1) begin
          nerr++; $display("FAIL single_rx dut%0d: got data %h start %0d expected a5 start 1",
                           d, rxd_at(d, r0[d]), rxs_at(d, r0[d]));
        end
        nchk++;
        if (rxc_at(d, r0[d]) - rise_cyc[0] !== s_of(d) + 2) begin
          nerr++; $display("FAIL single_latency dut%0d: got %0d expected %0d", d,
                           rxc_at(d, r0[d]) - rise_cyc[0], s_of(d) + 2);
        end
      end
      nchk++;
      if (fe_of(d) - f0[d] !== 1 || fec_of(d) !== csn_rise_cyc + s_of(d) + 1) begin
        nerr++; $display("FAIL single_frame_end dut%0d: got count %0d at %0d expected 1 at %0d", d,
                         fe_of(d) - f0[d], fec_of(d), csn_rise_cyc + s_of(d) + 1);
      end
    end
  endtask

  task automatic test_burst;
    int r0[2], b0;
    logic [7:0] tx_exp[3];
    tx_exp[0] = 8'h10; tx_exp[1] = 8'h20; tx_exp[2] = 8'h30;
    for (int d = 0; d < 2; d++) r0[d] = rxn_of(d);
    b0 = idx2;
    for (int b = 0; b < 3; b++) begin
      mo[b] = 8'(b + 1);
      txq[(b0 + b) % 256] = tx_exp[b];
    end
    do_frame(3, 8);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) - r0[d] !== 3) begin
        nerr++; $display("FAIL burst_rx_count dut%0d: got %0d expected 3", d, rxn_of(d) - r0[d]);
      end else begin
        for (int b = 0; b < 3; b++) begin
          nchk++;
          if (rxd_at(d, r0[d] + b) !== 8'(b + 1) || rxs_at(d, r0[d] + b) !== (b == 0)) begin
            nerr++; $display("FAIL burst_rx dut%0d byte%0d: got %h/%0d expected %h/%0d", d, b,
                             rxd_at(d, r0[d] + b), rxs_at(d, r0[d] + b), 8'(b + 1), b == 0);
          end
        end
      end
      for (int b = 0; b < 3; b++) begin
        nchk++;
        if (mi_got[d][b] !== tx_exp[b]) begin
          nerr++; $display("FAIL burst_miso dut%0d byte%0d: got %h expected %h", d, b, mi_got[d][b], tx_exp[b]);
        end
      end
      nchk++;
      if (idx_of(d) !== b0 + 4) begin
        nerr++; $display("FAIL burst_tx_loads dut%0d: got index %0d expected %0d", d, idx_of(d), b0 + 4);
      end
    end
  endtask

  task automatic test_abort;
    int r0[2], f0[2], b0;
    for (int d = 0; d < 2; d++) begin r0[d] = rxn_of(d); f0[d] = fe_of(d); end
    mo[0] = 8'hFF;
    do_frame(1, 5);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) !== r0[d] || fe_of(d) - f0[d] !== 1) begin
        nerr++; $display("FAIL abort dut%0d: got rx %0d frame_end %0d expected 0 and 1", d,
                         rxn_of(d) - r0[d], fe_of(d) - f0[d]);
      end
    end
    mo[0] = 8'h5A;
    b0 = idx2;
    do_frame(1, 8);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) - r0[d] !== 1) begin
        nerr++; $display("FAIL abort_next_count dut%0d: got %0d expected 1", d, rxn_of(d) - r0[d]);
      end else if (rxd_at(d, r0[d]) !== 8'h5A || rxs_at(d, r0[d]) !== 1'b1) begin
        nerr++; $display("FAIL abort_next_rx dut%0d: got %h/%0d expected 5a/1", d,
                         rxd_at(d, r0[d]), rxs_at(d, r0[d]));
      end
      nchk++;
      if (mi_got[d][0] !== txq[b0 % 256]) begin
        nerr++; $display("FAIL abort_next_miso dut%0d: got %h expected %h", d, mi_got[d][0], txq[b0 % 256]);
      end
    end
  endtask

  task automatic test_idle_clk;
    int r0[2], f0[2], bad;
    for (int d = 0; d < 2; d++) begin r0[d] = rxn_of(d); f0[d] = fe_of(d); end
    bad = 0;
    for (int t = 0; t < 32; t++) begin
      repeat (4) @(negedge clk);
      spi_clk  = ~spi_clk;
      spi_mosi = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        nchk++;
        if (miso_of(d) !== idle_of(d)) begin
          nerr++; $display("FAIL idle_miso dut%0d: got %b expected %b", d, miso_of(d), idle_of(d));
        end
      end
    end
    repeat (12) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) !== r0[d] || fe_of(d) !== f0[d]) begin
        nerr++; $display("FAIL idle_clk_events dut%0d: got rx %0d frame_end %0d expected 0 and 0", d,
                         rxn_of(d) - r0[d], fe_of(d) - f0[d]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int r0[2], f0[2], b0;
    logic [12:0] exp;
    for (int d = 0; d < 2; d++) begin r0[d] = rxn_of(d); f0[d] = fe_of(d); end
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    in_frame = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'($urandom);
      repeat (4) @(negedge clk); spi_clk = 1'b1;
      repeat (4) @(negedge clk); spi_clk = 1'b0;
    end
    reset_n = 1'b0;
    in_frame = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp = {8'h00, 4'b0000, idle_of(d)};
      nchk++;
      if (outs_of(d) !== exp) begin
        nerr++; $display("FAIL midreset_values dut%0d: got %h expected %h", d, outs_of(d), exp);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1'($urandom);
      repeat (4) @(negedge clk); spi_clk = 1'b1;
      repeat (4) @(negedge clk); spi_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    repeat (12) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) !== r0[d] || fe_of(d) !== f0[d]) begin
        nerr++; $display("FAIL midreset_ignored dut%0d: got rx %0d frame_end %0d expected 0 and 0", d,
                         rxn_of(d) - r0[d], fe_of(d) - f0[d]);
      end
    end
    mo[0] = 8'hC3;
    b0 = idx2;
    do_frame(1, 8);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) - r0[d] !== 1) begin
        nerr++; $display("FAIL midreset_next_count dut%0d: got %0d expected 1", d, rxn_of(d) - r0[d]);
      end else if (rxd_at(d, r0[d]) !== 8'hC3 || rxs_at(d, r0[d]) !== 1'b1) begin
        nerr++; $display("FAIL midreset_next_rx dut%0d: got %h/%0d expected c3/1", d,
                         rxd_at(d, r0[d]), rxs_at(d, r0[d]));
      end
      nchk++;
      if (mi_got[d][0] !== txq[b0 % 256]) begin
        nerr++; $display("FAIL midreset_next_miso dut%0d: got %h expected %h", d, mi_got[d][0], txq[b0 % 256]);
      end
    end
  endtask

  task automatic test_random_stream;
    int r0[2], b0;
    for (int d = 0; d < 2; d++) r0[d] = rxn_of(d);
    b0 = idx2;
    for (int b = 0; b < 64; b++) begin
      mo[b] = 8'($urandom);
      txq[(b0 + b) % 256] = 8'($urandom);
    end
    do_frame(64, 8);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rxn_of(d) - r0[d] !== 64) begin
        nerr++; $display("FAIL stream_rx_count dut%0d: got %0d expected 64", d, rxn_of(d) - r0[d]);
      end else begin
        for (int b = 0; b < 64; b++) begin
          nchk++;
          if (rxd_at(d, r0[d] + b) !== mo[b] || rxs_at(d, r0[d] + b) !== (b == 0)) begin
            nerr++; $display("FAIL stream_rx dut%0d byte%0d: got %h/%0d expected %h/%0d", d, b,
                             rxd_at(d, r0[d] + b), rxs_at(d, r0[d] + b), mo[b], b == 0);
          end
          nchk++;
          if (rxc_at(d, r0[d] + b) - rise_cyc[b] !== s_of(d) + 2) begin
            nerr++; $display("FAIL stream_latency dut%0d byte%0d: got %0d expected %0d", d, b,
                             rxc_at(d, r0[d] + b) - rise_cyc[b], s_of(d) + 2);
          end
        end
      end
      for (int b = 0; b < 64; b++) begin
        nchk++;
        if (mi_got[d][b] !== txq[(b0 + b) % 256]) begin
          nerr++; $display("FAIL stream_miso dut%0d byte%0d: got %h expected %h", d, b,
                           mi_got[d][b], txq[(b0 + b) % 256]);
        end
      end
      nchk++;
      if (bad_of(d) !== 0) begin
        nerr++; $display("FAIL rx_start_without_valid dut%0d: got %0d cycles expected 0", d, bad_of(d));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) txq[i] = 8'($urandom);
    test_reset();
    test_single();
    test_burst();
    test_abort();
    test_idle_clk();
    test_reset_mid();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
